// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam logic [2:0] RES_LOAD = 3'b001;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    // Operand bypass select; the younger M result wins over W.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                           input logic [4:0] rd_w, input logic wr_m,
                                           input logic wr_w);
        if (wr_m && rd_m != 5'd0 && rd_m == rs)
            return FWD_M;
        else if (wr_w && rd_w != 5'd0 && rd_w == rs)
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard controller signal bundle.
interface hazard_if #(parameter int CNT_W = 32);

    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E;
    logic [4:0]       RdE, RdM, RdW;
    logic [2:0]       ResultSrcE;
    logic             RegWriteM, RegWriteW;
    logic             PCSrcE, MultiCycleE;
    logic             StallF, StallD, StallE;
    logic             FlushD, FlushE, FlushM;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             MdStart, MdDone;
    logic [CNT_W-1:0] StallCount, FlushCount;

    // Pipeline side: provides stage info, consumes controls.
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
               RegWriteM, RegWriteW, PCSrcE, MultiCycleE,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
               ForwardAE, ForwardBE, MdStart, MdDone, StallCount, FlushCount
    );

    // Hazard controller side.
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
               RegWriteM, RegWriteW, PCSrcE, MultiCycleE,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM,
               ForwardAE, ForwardBE, MdStart, MdDone, StallCount, FlushCount
    );

endinterface

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count enabled cycles, hold once full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (inc && count != '1)
            count <= count + W'(1);
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage core: forwarding, load-use and
// redirect handling, mul/div stall sequencing and perf counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic     clk,
    input  logic     reset,
    hazard_if.slave  hz
);

    localparam int CW = $clog2(MD_LATENCY + 1);

    md_state_t     state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          lw_stall, md_stall;

    assign lw_stall = (hz.ResultSrcE == RES_LOAD) && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    // Detect cycle stalls too, so the op sees exactly MD_LATENCY frozen cycles.
    assign md_stall = (state == IDLE && hz.MultiCycleE) || (state == BUSY);

    assign hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
    assign hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);

    // Multi-cycle FSM state and remaining-cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state: DONE ignores MultiCycleE since the finished op is still in E.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: if (hz.MultiCycleE) begin
                state_nx = BUSY;
                cnt_nx   = CW'(MD_LATENCY - 1);
            end
            BUSY: begin
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1))
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Pipeline controls; a mul/div stall overrides redirects and load-use.
    always_comb begin
        hz.StallF  = 1'b0;
        hz.StallD  = 1'b0;
        hz.StallE  = 1'b0;
        hz.FlushD  = 1'b0;
        hz.FlushE  = 1'b0;
        hz.FlushM  = 1'b0;
        hz.MdStart = 1'b0;
        hz.MdDone  = (state == DONE);
        if (reset) begin
            hz.StallF  = (lw_stall && !hz.PCSrcE) || md_stall;
            hz.StallD  = hz.StallF;
            hz.StallE  = md_stall;
            hz.FlushD  = hz.PCSrcE && !md_stall;
            hz.FlushE  = (lw_stall || hz.PCSrcE) && !md_stall;
            hz.FlushM  = md_stall;
            hz.MdStart = (state == IDLE) && hz.MultiCycleE;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hz.StallF),
        .count (hz.StallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hz.FlushD),
        .count (hz.FlushCount)
    );

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Pipeline hazard controller for the 5-stage RISC-V core. It drives the stall, clear and flush inputs of the F, D, E and M stage registers, including the clear of the D/E control register. It computes the E-stage operand forwarding selects, detects load-use hazards and branch/jump redirects, and sequences multi-cycle execute operations (mul/div) with a stall FSM. It also keeps saturating stall and flush performance counters.

Parameters:
MD_LATENCY, 4, total stall cycles for a multi-cycle E-stage op (legal range >= 2)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
Rs1D, Rs2D  in  5  source registers of instruction in D
Rs1E, Rs2E  in  5  source registers of instruction in E
RdE, RdM, RdW  in  5  destination registers in E/M/W
ResultSrcE  in  3  result select of instruction in E
RegWriteM, RegWriteW  in  1  write-enable of instruction in M/W
PCSrcE  in  1  taken branch/jump resolved in E
MultiCycleE  in  1  instruction in E is a multi-cycle op
StallF, StallD, StallE  out  1  hold F/D/E pipeline registers
FlushD, FlushE, FlushM  out  1  clear D/E/M pipeline registers (FlushE drives D/E clear)
ForwardAE, ForwardBE  out  2  E operand select: 00 RF, 01 W result, 10 M ALU result
MdStart  out  1  one-cycle start pulse to multi-cycle unit
MdDone  out  1  multi-cycle op completes; E advances this cycle
StallCount, FlushCount  out  CNT_W  saturating perf counters

Behaviour:
- Reset (reset==0): FSM=IDLE, internal counter=0, StallCount=FlushCount=0, MdDone=0. All stall/flush/MdStart outputs are forced 0 while reset is asserted. Reset mid-BUSY aborts the op with no MdDone.
- Forwarding, combinational, per operand:
  - 10 if RegWriteM & RdM!=0 & RdM==RsxE;
  - else 01 if RegWriteW & RdW!=0 & RdW==RsxE;
  - else 00.
  - M has priority over W.
- lwStall = (ResultSrcE==RES_LOAD) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- mdStall = (state==IDLE & MultiCycleE) | (state==BUSY).
- StallF = StallD = (lwStall & ~PCSrcE) | mdStall. Redirect dominates a load-use stall, so fetch of the target proceeds.
- FlushD = PCSrcE & ~mdStall.
- FlushE = (lwStall | PCSrcE) & ~mdStall.
- StallE = mdStall.
- FlushM = mdStall, which inserts bubbles into M while E is frozen.
- MultiCycleE and PCSrcE are never asserted together; if they are, mdStall wins and PCSrcE is ignored until DONE.
- FSM, states IDLE, BUSY, DONE:
  - IDLE: MultiCycleE -> BUSY, counter<=MD_LATENCY-1, MdStart=1 (combinational, this cycle only).
  - BUSY: counter decrements each cycle; when counter==1 -> DONE.
  - DONE: no stalls, MdDone=1, MultiCycleE ignored (same instruction leaving E) -> IDLE.
  - Resulting timing: exactly MD_LATENCY stall cycles (detect cycle + MD_LATENCY-1 BUSY cycles), then one DONE cycle.
  - Back-to-back multi-cycle ops: the second is detected in IDLE the cycle after DONE.
- Counters:
  - StallCount += 1 each cycle StallF==1.
  - FlushCount += 1 each cycle FlushD==1.
  - Both saturate at all-ones; no wrap.

Decomposition:
- hazard_pkg:
  - RES_LOAD=3'b001;
  - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - md_state_t enum {IDLE, BUSY, DONE}.
- Sub-module sat_counter #(W), with increment enable and async active-low reset; instantiated twice.

Test Plan:
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Same with RdM=0 -> ForwardAE=01. Rs2E=0 with RdW=0 -> ForwardBE=00.
- Load-use: ResultSrcE=001, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, FlushD=0 for one cycle. RdE=0 -> no stall.
- Redirect: PCSrcE=1 together with lwStall conditions -> FlushD=FlushE=1, StallF=StallD=0, FlushCount increments by 1.
- Multi-cycle, MD_LATENCY=4: MultiCycleE high from cycle t -> MdStart only at t; StallF/D/E and FlushM high t..t+3; MdDone=1 at t+4; IDLE at t+5; StallCount +4.
- Reset mid-op: reset=0 at t+2 of a multi-cycle op -> all stalls 0 immediately, counters 0, no MdDone. Release with MultiCycleE still high -> new op starts with a fresh MdStart.
- Saturation: CNT_W=4, hold lwStall for 20 cycles -> StallCount stops at 15.
